// File: rtl/countnox_arbiter.sv
// Round-robin front end for a shared CountNoX engine: grants one of NREQ
// requesters, drives the engine, watchdogs it, and returns the count to the winner.
module countnox_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 300
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_freq,
  output logic              rsp_err,
  output logic              busy,
  output logic              eng_go,
  output logic [7:0]        eng_x,
  input  logic              eng_done,
  input  logic [7:0]        eng_freq
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [WW-1:0]   wd_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [7:0]      rsp_freq_q;
  logic            rsp_err_q;
  logic            busy_q;
  logic            eng_go_q;
  logic [7:0]      eng_x_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [7:0]      win_x;

  // First active requester scanning upward from the round-robin pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_q + IW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_x = req_x[win_idx*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_freq_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      eng_go_q    <= 1'b0;
      eng_x_q     <= 8'h00;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            win_q    <= win_idx;
            eng_x_q  <= win_x;
            gnt_q    <= NREQ'(1) << win_idx;
            eng_go_q <= 1'b1;
            busy_q   <= 1'b1;
            wd_q     <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // Engine completion wins over a watchdog expiry in the same cycle
          if (eng_done) begin
            rsp_freq_q  <= eng_freq;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= NREQ'(1) << win_q;
            eng_go_q    <= 1'b0;
            state_q     <= RESP;
          end else if (wd_q == WW'(TIMEOUT - 1)) begin
            rsp_freq_q  <= 8'h00;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NREQ'(1) << win_q;
            eng_go_q    <= 1'b0;
            state_q     <= RESP;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        RESP: begin
          ptr_q   <= win_q + IW'(1);
          state_q <= GAP;
        end
        GAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_freq  = rsp_freq_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign eng_go    = eng_go_q;
  assign eng_x     = eng_x_q;

endmodule

// File: tb/tb_countnox_arbiter.sv
// Directed bench for countnox_arbiter: the bench plays the engine and checks
// grant order, response timing, watchdog, reset abort and eng_x stability.
module tb_countnox_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_x;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_freq;
  logic        rsp_err;
  logic        busy;
  logic        eng_go;
  logic [7:0]  eng_x;
  logic        eng_done;
  logic [7:0]  eng_freq;

  int n_checks = 0;
  int n_errors = 0;

  countnox_arbiter #(.NREQ(4), .TIMEOUT(300)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_x     (req_x),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_freq  (rsp_freq),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .eng_go    (eng_go),
    .eng_x     (eng_x),
    .eng_done  (eng_done),
    .eng_freq  (eng_freq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Waits for a grant, serves it as the engine (done in RUN cycle n_done, 0 = never),
  // and checks RUN, RESP and GAP. Returns at the GAP negedge.
  task automatic run_txn(input logic [3:0] eg, input logic [7:0] ex, input int n_done,
                         input logic [7:0] f, input logic ee, input logic [7:0] ef,
                         input int exp_runs, input bit chg);
    int k;
    int go_bad;
    int gnt_bad;
    for (int w = 0; w < 20 && gnt == 4'b0; w++) @(negedge clk);
    check_eq("grant", gnt, eg);
    check_eq("eng_x_at_grant", eng_x, ex);
    check_eq("busy_run", busy, 1'b1);
    if (chg) begin
      req_x[7:0] = 8'h22;
      req        = 4'b0000;
    end
    go_bad  = 0;
    gnt_bad = 0;
    for (k = 1; k <= 400; k++) begin
      if (eng_go !== 1'b1) go_bad++;
      if (k > 1 && gnt !== 4'b0) gnt_bad++;
      if (k == n_done) begin
        eng_done = 1'b1;
        eng_freq = f;
      end
      @(posedge clk);
      @(negedge clk);
      eng_done = 1'b0;
      eng_freq = 8'h00;
      if (rsp_valid != 4'b0) break;
    end
    check_eq("run_cycles", k, exp_runs);
    check_eq("eng_go_in_run", go_bad, 0);
    check_eq("gnt_single_pulse", gnt_bad, 0);
    check_eq("rsp_valid", rsp_valid, eg);
    check_eq("rsp_freq", rsp_freq, ef);
    check_eq("rsp_err", rsp_err, ee);
    check_eq("eng_go_resp", eng_go, 1'b0);
    check_eq("eng_x_resp", eng_x, ex);
    @(negedge clk);
    check_eq("rsp_valid_gap", rsp_valid, 4'b0);
    check_eq("eng_go_gap", eng_go, 1'b0);
    check_eq("busy_gap", busy, 1'b1);
    check_eq("eng_x_gap", eng_x, ex);
    check_eq("rsp_freq_hold", rsp_freq, ef);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] xs [4];

  initial begin
    reset    = 1'b0;
    req      = 4'b0;
    req_x    = 32'h0;
    eng_done = 1'b0;
    eng_freq = 8'h00;
    xs[0] = 8'h10; xs[1] = 8'h20; xs[2] = 8'h30; xs[3] = 8'h40;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_gnt", gnt, 4'b0);
    check_eq("rst_rsp_valid", rsp_valid, 4'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_eng_go", eng_go, 1'b0);
    check_eq("rst_eng_x", eng_x, 8'h00);
    check_eq("rst_rsp_freq", rsp_freq, 8'h00);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b1;

    // Single long request
    req   = 4'b0001;
    req_x = 32'h0;
    run_txn(4'b0001, 8'h00, 258, 8'h05, 1'b0, 8'h05, 258, 1'b0);
    req = 4'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_rsp_freq_hold", rsp_freq, 8'h05);

    // Round-robin with all four held
    apply_reset();
    req   = 4'b1111;
    req_x = {xs[3], xs[2], xs[1], xs[0]};
    for (int i = 0; i < 5; i++) begin
      run_txn(4'(1 << (i % 4)), xs[i % 4], 10, xs[i % 4], 1'b0, xs[i % 4], 10, 1'b0);
      if (i == 4) req = 4'b0;
    end
    @(negedge clk);

    // Watchdog timeout, then done exactly on the last watchdog cycle
    req = 4'b0100;
    run_txn(4'b0100, xs[2], 0, 8'h00, 1'b1, 8'h00, 300, 1'b0);
    run_txn(4'b0100, xs[2], 300, 8'h07, 1'b0, 8'h07, 300, 1'b0);
    req = 4'b0;
    @(negedge clk);

    // Reset in RUN cycle 50 aborts the request without a response
    apply_reset();
    req = 4'b0010;
    for (int w = 0; w < 20 && gnt == 4'b0; w++) @(negedge clk);
    check_eq("abort_grant", gnt, 4'b0010);
    repeat (49) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_gnt", gnt, 4'b0);
    check_eq("abort_rsp_valid", rsp_valid, 4'b0);
    check_eq("abort_eng_go", eng_go, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_eng_x", eng_x, 8'h00);
    check_eq("abort_rsp_freq", rsp_freq, 8'h00);
    check_eq("abort_rsp_err", rsp_err, 1'b0);
    reset = 1'b1;
    req   = 4'b0011;
    run_txn(4'b0001, xs[0], 5, 8'h33, 1'b0, 8'h33, 5, 1'b0);
    req = 4'b0;
    @(negedge clk);

    // req_x changed and req dropped after grant: eng_x holds, response still issued
    req        = 4'b0001;
    req_x[7:0] = 8'h11;
    run_txn(4'b0001, 8'h11, 7, 8'h09, 1'b0, 8'h09, 7, 1'b1);
    @(negedge clk);
    check_eq("stab_eng_x_idle", eng_x, 8'h11);
    check_eq("stab_no_regrant", gnt, 4'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countnox_arbiter.md
COUNTNOX_ARBITER -- requirements
Module: countnox_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter: TIMEOUT, 300, max engine cycles before abort.
REQ-003 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port: req  input  4  per-requester count request, level, held until rsp_valid.
REQ-006 SHALL have port: req_x  input  32  search values, requester i on bits [8i+7:8i], stable while req[i] high.
REQ-007 SHALL have port: gnt  output  4  one-hot, one-cycle pulse when requester i accepted.
REQ-008 SHALL have port: rsp_valid  output  4  one-hot, one-cycle pulse when result for requester i ready.
REQ-009 SHALL have port: rsp_freq  output  8  count result, valid with rsp_valid.
REQ-010 SHALL have port: rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: eng_go  output  1  go to CountNoX engine.
REQ-013 SHALL have port: eng_x  output  8  search value to engine.
REQ-014 SHALL have port: eng_done  input  1  engine completion.
REQ-015 SHALL have port: eng_freq  input  8  engine count, valid while eng_done high.

Function
REQ-016 SHALL implement states IDLE, RUN, RESP, GAP, all registered.
REQ-017 IDLE: on edge with any req high, SHALL select winner by round-robin from pointer ptr (ptr, ptr+1, ... mod 4), latch req_x of winner into eng_x, go RUN; gnt[winner]=1 during first RUN cycle only.
REQ-018 RUN: eng_go SHALL be 1 for every RUN cycle; watchdog counter starts at 0 on entry, +1 per RUN cycle.
REQ-019 RUN: eng_done sampled 1 SHALL capture eng_freq into rsp_freq, clear rsp_err, go RESP.
REQ-020 RUN: watchdog reaching TIMEOUT with eng_done 0 SHALL set rsp_freq=0, rsp_err=1, go RESP; eng_done takes priority if both in same cycle.
REQ-021 RESP: rsp_valid[winner]=1 for exactly one cycle, eng_go=0, ptr <= (winner+1) mod 4, go GAP.
REQ-022 GAP: eng_go=0 for one cycle so engine returns to idle; req ignored; go IDLE.
REQ-023 Latency: req in IDLE at edge t -> gnt and eng_go at t+1; eng_done at edge d -> rsp_valid at d+1; next grant no earlier than d+3.
REQ-024 eng_x SHALL stay constant from RUN entry until next grant; req_x changes after grant SHALL be ignored.
REQ-025 Requester dropping req mid-service SHALL not abort; rsp_valid still issued.
REQ-026 Requester still asserting req in IDLE after its rsp_valid SHALL be treated as a new request, subject to round-robin.
REQ-027 gnt, rsp_valid SHALL never have more than one bit set; outside their pulses all zero.
REQ-028 rsp_freq, rsp_err SHALL hold last value until next RESP.
REQ-029 busy SHALL be 0 only in IDLE.

Reset
REQ-030 reset sampled 0 SHALL force IDLE, ptr=0, watchdog=0, gnt=0, rsp_valid=0, rsp_freq=0, rsp_err=0, eng_go=0, eng_x=0, busy=0 at that edge, from any state.
REQ-031 Reset during RUN SHALL drop eng_go next edge and issue no rsp_valid for the aborted request.
REQ-032 First cycle after reset release SHALL arbitrate normally with ptr=0.

Verification
REQ-033 Single: reset, req=0001, req_x[7:0]=0x00, engine model done after 258 cycles with freq 0x05 -> gnt=0001 one cycle, eng_x=0x00, rsp_valid=0001 one cycle, rsp_freq=0x05, rsp_err=0.
REQ-034 Round-robin: req=1111 held, x values 0x10/0x20/0x30/0x40, engine done after 10 cycles -> grants in order 0001,0010,0100,1000,0001; each rsp_freq matches its x; no rsp_valid overlaps.
REQ-035 Timeout: req=0100, engine never asserts done -> after 300 RUN cycles rsp_valid=0100, rsp_err=1, rsp_freq=0x00, eng_go low in RESP and GAP.
REQ-036 Done at timeout edge: eng_done=1, eng_freq=0x07 on cycle 300 -> rsp_err=0, rsp_freq=0x07.
REQ-037 Reset mid-RUN: req=0010, reset low at RUN cycle 50 -> all outputs zero next edge, no rsp_valid; after release with req=0011 -> gnt=0001 first (ptr=0).
REQ-038 Stability: req=0001, req_x changed 0x11->0x22 after grant -> eng_x remains 0x11 through RUN and GAP.
